// File: rtl/pcm_out_fifo_pkg.sv
// pcm_out_fifo_pkg: constants and types shared by the PCM output FIFO,
// its lane serializer and the overlap/add stage that feeds the group bus.
// Contents: sample width, lanes per group, lane index type and helpers.
package pcm_out_fifo_pkg;

  // One group on the parallel bus carries four PCM samples, lane 0 in the LSBs.
  localparam int WORD_LENGTH = 16;
  localparam int LANES       = 4;
  localparam int LANE_BITS   = 2;
  localparam int BUS_SIZE    = LANES * WORD_LENGTH;

  typedef logic [LANE_BITS-1:0] lane_t;

  localparam lane_t FIRST_LANE = lane_t'(0);
  localparam lane_t LAST_LANE  = lane_t'(LANES - 1);

  // Lane following `cur`; wraps back to lane 0 after the last lane.
  function automatic lane_t next_lane(input lane_t cur);
    return (cur == LAST_LANE) ? FIRST_LANE : lane_t'(cur + 1'b1);
  endfunction

  // Bit offset of a lane inside a group of `width`-bit samples.
  function automatic int lane_base(input lane_t idx, input int width);
    return int'(idx) * width;
  endfunction

endpackage

// File: rtl/pcm_lane_serializer.sv
// pcm_lane_serializer: turns one buffered 4-sample group into four
// valid/ready sample transfers, lane 0 first.
// Latency: combinational from group to sampleOut; lane advances per transfer.
// Backpressure: sampleReady=0 holds the lane, so sampleOut stays stable.
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   group, groupValid   group at the head of the FIFO and its presence
//   sampleReady         consumer accepts sampleOut this cycle
//   sampleOut/Valid     current sample (0 when no group is present)
//   groupDone           last lane transferred this cycle; pop the group
module pcm_lane_serializer
  import pcm_out_fifo_pkg::*;
#(
  parameter int wordLength = WORD_LENGTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [LANES*wordLength-1:0] group,
  input  logic                        groupValid,
  input  logic                        sampleReady,
  output logic [wordLength-1:0]       sampleOut,
  output logic                        sampleValid,
  output logic                        groupDone
);

  lane_t lane;
  logic  xfer;

  assign sampleValid = groupValid;
  assign xfer        = groupValid && sampleReady;
  assign groupDone   = xfer && (lane == LAST_LANE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane <= FIRST_LANE;
    end else if (xfer) begin
      lane <= next_lane(lane);
    end
  end

  // Output is forced to zero while nothing is buffered so the consumer never
  // sees stale storage contents.
  always_comb begin
    sampleOut = '0;
    if (groupValid) begin
      sampleOut = group[lane_base(lane, wordLength) +: wordLength];
    end
  end

endmodule

// File: rtl/pcm_out_fifo.sv
// pcm_out_fifo: circular FIFO of 4-sample PCM groups from the overlap/add
// stage, serialized one sample per valid/ready transfer (first-word fall-through).
// Latency: group written at edge k is visible on sampleOut in cycle k+1.
// Backpressure: loads while full are dropped and latch the sticky overflow flag.
// Ports:
//   clock, reset              rising-edge clock, async active-low reset
//   load, dataBus             write strobe and 4-lane group
//   full, empty, level        occupancy in groups, 0..depth
//   overflow, clearOverflow   sticky lost-group flag and its synchronous clear
//   sampleOut/Valid/Ready     serialized PCM output handshake
module pcm_out_fifo
  import pcm_out_fifo_pkg::*;
#(
  parameter int wordLength = WORD_LENGTH,
  parameter int busSize    = LANES * wordLength,
  parameter int depth      = 8,
  parameter int addrWidth  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [busSize-1:0]    dataBus,
  output logic                  full,
  output logic                  empty,
  output logic [addrWidth:0]    level,
  output logic                  overflow,
  input  logic                  clearOverflow,
  output logic [wordLength-1:0] sampleOut,
  output logic                  sampleValid,
  input  logic                  sampleReady
);

  typedef logic [addrWidth-1:0] ptr_t;
  typedef logic [addrWidth:0]   cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(depth);

  logic [busSize-1:0] mem [depth];

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count;

  logic push;
  logic pop;
  logic reject;

  // Occupancy flags come straight from the group count; full is therefore the
  // pre-edge value, so a pop on the same edge does not rescue a load.
  assign full   = (count == DEPTH_CNT);
  assign empty  = (count == '0);
  assign level  = count;

  assign push   = load && !full;
  assign reject = load && full;

  // Storage is deliberately left out of reset; only pointers and count matter.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= dataBus;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;  // depth is a power of two: natural wrap
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A rejected load on the same edge as a clear wins, so no loss goes unseen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (reject) begin
      overflow <= 1'b1;
    end else if (clearOverflow) begin
      overflow <= 1'b0;
    end
  end

  pcm_lane_serializer #(
    .wordLength (wordLength)
  ) u_serializer (
    .clock       (clock),
    .reset       (reset),
    .group       (mem[rd_ptr]),
    .groupValid  (!empty),
    .sampleReady (sampleReady),
    .sampleOut   (sampleOut),
    .sampleValid (sampleValid),
    .groupDone   (pop)
  );

endmodule

// File: tb/tb_pcm_out_fifo.sv
// tb_pcm_out_fifo: directed and randomized stimulus for pcm_out_fifo, checked
// against a sample-queue reference model (level = groups touched by queue).
module tb_pcm_out_fifo;

  logic        clock;
  logic        reset;
  logic        load;
  logic [63:0] dataBus;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        overflow;
  logic        clearOverflow;
  logic [15:0] sampleOut;
  logic        sampleValid;
  logic        sampleReady;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: every buffered sample in output order, plus the flag.
  logic [15:0] mq[$];
  logic        m_ovf;

  pcm_out_fifo dut (
    .clock         (clock),
    .reset         (reset),
    .load          (load),
    .dataBus       (dataBus),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .clearOverflow (clearOverflow),
    .sampleOut     (sampleOut),
    .sampleValid   (sampleValid),
    .sampleReady   (sampleReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int m_level();
    return (mq.size() + 3) / 4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(sampleValid), 64'(mq.size() > 0));
    chk({tag, ".sample"}, 64'(sampleOut), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
    chk({tag, ".level"}, 64'(level), 64'(m_level()));
    chk({tag, ".full"}, 64'(full), 64'(m_level() == 8));
    chk({tag, ".empty"}, 64'(empty), 64'(mq.size() == 0));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model from pre-edge state, compare
  // #1 after the rising edge.
  task automatic cyc(input string tag, input logic ld, input logic [63:0] d,
                     input logic rdy, input logic clr);
    bit accept, rej, xfer;
    load = ld; dataBus = d; sampleReady = rdy; clearOverflow = clr;
    accept = ld && (m_level() < 8);
    rej    = ld && (m_level() == 8);
    xfer   = rdy && (mq.size() > 0);
    if (xfer) void'(mq.pop_front());
    if (accept) for (int i = 0; i < 4; i++) mq.push_back(d[i*16 +: 16]);
    if (rej) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    logic [63:0] g;
    int          lvl_before;
    reset = 1'b0; load = 1'b0; dataBus = '0; sampleReady = 1'b0; clearOverflow = 1'b0;
    model_reset();

    // Reset held for two cycles, then idle.
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    reset = 1'b1;
    cyc("idle", 1'b0, 64'd0, 1'b0, 1'b0);

    // Single group with ready high: no bypass on the load edge, then 1,2,3,4.
    cyc("single.load", 1'b1, 64'h0004_0003_0002_0001, 1'b1, 1'b0);
    chk("single.first", 64'(sampleOut), 64'h1);
    for (int i = 0; i < 4; i++) cyc("single.drain", 1'b0, 64'd0, 1'b1, 1'b0);
    chk("single.empty_after", 64'(empty), 64'd1);

    // Backpressure pattern 1,0,0,1,1,1.
    cyc("bp.load", 1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0, 1'b0);
    chk("bp.first", 64'(sampleOut), 64'hAAAA);
    begin
      logic [5:0] pat;
      pat = 6'b111001;
      for (int i = 0; i < 6; i++) cyc("bp.step", 1'b0, 64'd0, pat[i], 1'b0);
    end

    // Fill to full, then overflow; clear racing a rejected load keeps the flag.
    for (int gi = 1; gi <= 9; gi++) begin
      g = {16'(gi*4+3), 16'(gi*4+2), 16'(gi*4+1), 16'(gi*4)};
      cyc("fill", 1'b1, g, 1'b0, 1'b0);
      if (gi == 8) chk("fill.full8", 64'(full), 64'd1);
    end
    chk("fill.ovf9", 64'(overflow), 64'd1);
    chk("fill.level", 64'(level), 64'd8);
    cyc("ovf.set_wins", 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b1);
    chk("ovf.kept", 64'(overflow), 64'd1);
    // Load on the edge of a pop while full: still rejected.
    for (int i = 0; i < 3; i++) cyc("fullpop.pre", 1'b0, 64'd0, 1'b1, 1'b0);
    cyc("fullpop.rej", 1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
    for (int i = 0; i < 28; i++) cyc("drain", 1'b0, 64'd0, 1'b1, 1'b0);
    chk("drain.empty", 64'(empty), 64'd1);
    cyc("ovf.clear", 1'b0, 64'd0, 1'b0, 1'b1);
    chk("ovf.cleared", 64'(overflow), 64'd0);

    // Wrap with loads coinciding with each lane-3 pop: values g*4+lane, 0..79.
    cyc("wrap.prime", 1'b1, {16'd3, 16'd2, 16'd1, 16'd0}, 1'b0, 1'b0);
    begin
      int gi;
      int expect_s;
      gi = 1;
      expect_s = 0;
      for (int c = 0; c < 80; c++) begin
        chk("wrap.seq", 64'(sampleOut), 64'(expect_s));
        expect_s++;
        lvl_before = m_level();
        if ((mq.size() % 4 == 1) && gi < 20) begin
          g = {16'(gi*4+3), 16'(gi*4+2), 16'(gi*4+1), 16'(gi*4)};
          gi++;
          cyc("wrap.ldpop", 1'b1, g, 1'b1, 1'b0);
          chk("wrap.level_const", 64'(level), 64'(lvl_before));
        end else begin
          cyc("wrap.run", 1'b0, 64'd0, 1'b1, 1'b0);
        end
      end
      chk("wrap.empty", 64'(empty), 64'd1);
    end

    // Reset mid-group discards everything; next group starts at lane 0.
    cyc("mid.ld0", 1'b1, 64'h0A03_0A02_0A01_0A00, 1'b0, 1'b0);
    cyc("mid.ld1", 1'b1, 64'h0B03_0B02_0B01_0B00, 1'b1, 1'b0);
    cyc("mid.cons", 1'b0, 64'd0, 1'b1, 1'b0);
    load = 1'b0; sampleReady = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_all("mid.reset");
    @(negedge clock);
    reset = 1'b1;
    cyc("mid.new", 1'b1, 64'h0C03_0C02_0C01_0C00, 1'b0, 1'b0);
    chk("mid.lane0", 64'(sampleOut), 64'h0C00);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      cyc("rand",
          1'($urandom_range(0, 99) < 35),
          {$urandom, $urandom},
          1'($urandom_range(0, 99) < 70),
          1'($urandom_range(0, 99) < 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
